// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among P_N requesters.
// One byte per grant; waits for the transmitter's ready low/high handshake before the next launch.
module uart_tx_arbiter #(
    parameter int P_N       = 4,
    parameter int P_DW      = 8,
    parameter int P_BUSY_TO = 4
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic [P_N-1:0]      i_Req,
    input  logic [P_N*P_DW-1:0] i_Data,
    output logic [P_N-1:0]      o_Ack,
    input  logic                i_TxReady,
    output logic                o_fTx,
    output logic [P_DW-1:0]     o_TxData,
    output logic                o_Busy,
    output logic [2:0]          o_GntIdx,
    output logic                o_Fault,
    output logic [7:0]          o_FrameCnt
);

    localparam int TO_W = $clog2(P_BUSY_TO + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_LOW,
        S_WAIT_HIGH
    } state_t;

    state_t            state_q;
    logic [2:0]        ptr_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [P_N-1:0]    ack_q;
    logic              ftx_q;
    logic [P_DW-1:0]   txdata_q;
    logic              busy_q;
    logic [2:0]        gnt_q;
    logic              fault_q;
    logic [7:0]        frame_q;

    logic              win_vld_d;
    logic [2:0]        win_idx_d;
    logic [P_N-1:0]    win_onehot_d;
    logic [P_DW-1:0]   win_data_d;

    // Distance i walks ptr+1, ptr+2, ... so the first asserted request after the pointer wins.
    always_comb begin
        win_vld_d    = 1'b0;
        win_idx_d    = '0;
        win_onehot_d = '0;
        win_data_d   = '0;
        for (int unsigned i = 0; i < P_N; i++) begin
            for (int unsigned j = 0; j < P_N; j++) begin
                if (!win_vld_d && i_Req[j] &&
                    (j == (32'(ptr_q) + i + 32'd1) % 32'(P_N))) begin
                    win_vld_d       = 1'b1;
                    win_idx_d       = 3'(j);
                    win_onehot_d[j] = 1'b1;
                    win_data_d      = i_Data[j*P_DW +: P_DW];
                end
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= 3'(P_N - 1);
            to_cnt_q <= '0;
            ack_q    <= '0;
            ftx_q    <= 1'b0;
            txdata_q <= '0;
            busy_q   <= 1'b0;
            gnt_q    <= '0;
            fault_q  <= 1'b0;
            frame_q  <= '0;
        end else begin
            ack_q <= '0;
            ftx_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_TxReady && win_vld_d) begin
                        ack_q    <= win_onehot_d;
                        ftx_q    <= 1'b1;
                        txdata_q <= win_data_d;
                        gnt_q    <= win_idx_d;
                        ptr_q    <= win_idx_d;
                        frame_q  <= frame_q + 8'd1;
                        to_cnt_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_WAIT_LOW;
                    end
                end
                S_WAIT_LOW: begin
                    if (!i_TxReady) begin
                        state_q <= S_WAIT_HIGH;
                    end else if (to_cnt_q == TO_W'(P_BUSY_TO - 1)) begin
                        fault_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (i_TxReady) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Ack      = ack_q;
    assign o_fTx      = ftx_q;
    assign o_TxData   = txdata_q;
    assign o_Busy     = busy_q;
    assign o_GntIdx   = gnt_q;
    assign o_Fault    = fault_q;
    assign o_FrameCnt = frame_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among `P_N` independent requesters (push-button encoder, Rx echo path, status reporter, and so on). It accepts one byte per grant, drives the transmitter's start strobe and data bus, and tracks the transmitter's ready flag so a new byte is never launched mid-frame. It sits between the request sources and `UART_TX` in the UART top level, replacing ad-hoc `ready & request` gating.

## Interface
Parameters:
- `P_N`, 4, number of requesters (2..8).
- `P_DW`, 8, data width per requester.
- `P_BUSY_TO`, 4, cycles to wait for the transmitter to drop ready after a start strobe before declaring a fault.

Ports:
- `i_Clk`  in  1  system clock; all logic on its rising edge.
- `i_Rst`  in  1  reset, asynchronous, active-high.
- `i_Req`  in  `P_N`  request per source; held high with data stable until acked.
- `i_Data`  in  `P_N*P_DW`  flattened request data; source k occupies bits [k*P_DW +: P_DW].
- `o_Ack`  out  `P_N`  one-hot, one-cycle pulse: source k's byte captured.
- `i_TxReady`  in  1  transmitter idle flag (`Tx_fReady`).
- `o_fTx`  out  1  one-cycle start strobe to the transmitter.
- `o_TxData`  out  `P_DW`  byte to transmit; stable from the `o_fTx` cycle until the next grant.
- `o_Busy`  out  1  high in any state other than IDLE.
- `o_GntIdx`  out  3  index of the most recently granted source.
- `o_Fault`  out  1  sticky; set when the transmitter never drops ready after a start strobe (timeout).
- `o_FrameCnt`  out  8  frames launched; wraps 255→0.

## Operation
- States: IDLE, WAIT_LOW, WAIT_HIGH.
- IDLE: if `i_TxReady`=1 and `|i_Req`, select the winner, then on the next edge:
  - capture `o_TxData` ← winner's data;
  - pulse `o_Ack[winner]` and `o_fTx` together;
  - set `o_GntIdx` and the round-robin pointer ← winner;
  - increment `o_FrameCnt`;
  - go to WAIT_LOW.
- IDLE with `i_TxReady`=0 or no request: hold state. Requests are not queued.
- Round-robin: search starts at pointer+1 modulo `P_N`; the first asserted request wins. Reset pointer is `P_N-1`, so source 0 has first priority after reset.
- WAIT_LOW:
  - `i_TxReady`=0 → WAIT_HIGH.
  - Otherwise increment the timeout counter. After `P_BUSY_TO` cycles with ready still high, set `o_Fault` and go to IDLE.
- WAIT_HIGH: `i_TxReady`=1 → IDLE.
- Counter widths: the timeout counter has width clog2(`P_BUSY_TO`+1) and is cleared on entry to WAIT_LOW.
- Withdrawn request: a request dropped before its ack is simply not served. No error is raised.
- Back-to-back: a request still high on the cycle after its ack counts as a new request. Round-robin then serves other pending sources first.
- `o_Fault` clears only on reset.

## Timing
- Reset values: state IDLE, `o_Ack`=0, `o_fTx`=0, `o_TxData`=0, `o_Busy`=0, `o_GntIdx`=0, pointer=`P_N-1`, `o_Fault`=0, `o_FrameCnt`=0.
- Reset asserted mid-frame clears all outputs asynchronously, including `o_fTx`. The pending byte is dropped and not re-acked.
- Latency: one edge from request-with-ready sampled in IDLE to `o_fTx`/`o_Ack` high.
- `o_fTx` is high exactly one cycle per grant. `o_TxData` is valid in that same cycle.
- Minimum spacing between two `o_fTx` pulses is 3 cycles (IDLE → WAIT_LOW → WAIT_HIGH → IDLE). In practice it is one frame time plus 2 cycles.
- `o_Busy` goes high in the `o_fTx` cycle and low in the first IDLE cycle.
- `o_Ack` never pulses while `i_TxReady`=0 or while not in IDLE.

## Test plan
- Reset then single request: `i_Req`=0001, data0=0x41, ready=1 → next cycle `o_fTx`=1, `o_Ack`=0001, `o_TxData`=0x41, `o_FrameCnt`=1. A ready low/high handshake then returns the block to IDLE.
- All four requests held continuously with data 0x10..0x13 and a transmitter model (10-cycle busy) → grant order 0,1,2,3,0. `o_FrameCnt` increments by one per frame.
- Request while `i_TxReady`=0 → no ack. Raise ready → ack on the following edge.
- Transmitter model never drops ready after the strobe → after 4 cycles `o_Fault`=1 and the state is IDLE. The next request is still served.
- Assert `i_Rst` in WAIT_HIGH → all outputs 0 immediately. After release, source 0 wins a simultaneous 1111 request.
- Launch 256 frames → `o_FrameCnt` wraps to 0 with no effect on arbitration.
